fifo_byte_packer: RTL and testbench
===================================

FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DATA_WIDTH, default 24, meaning the FIFO word width in bits, which SHALL be a multiple of 8.
REQ-002 The block SHALL derive localparam NBYTES = FIFO_DATA_WIDTH/8 as the number of bytes per FIFO word.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wr_clk  input  1  clock for all state in this block, shared with the FIFO write side.
REQ-005 in_data  input  8  byte from the upstream source.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a byte this cycle; a byte is transferred when in_valid && in_ready at the wr_clk rising edge.
REQ-008 in_sof  input  1  qualified by in_valid; marks the byte as byte 0 of a new word.
REQ-009 fifo_wr_en  output  1  FIFO write strobe.
REQ-010 fifo_din  output  FIFO_DATA_WIDTH  FIFO write data.
REQ-011 fifo_full  input  1  FIFO full flag; this block SHALL never assert fifo_wr_en while it is high.
REQ-012 drop_count  output  16  count of dropped words; this port SHALL be present only when FIFO_PACKER_DROP_EN is defined.

Function
REQ-013 The block SHALL run a two-state FSM, COLLECT and HOLD, with a byte index idx in the range 0..NBYTES-1.
REQ-014 Each accepted byte SHALL be written to fifo_din[8*idx+7 : 8*idx], filling LSB first.
REQ-015 After each accepted byte idx SHALL increment; accepting byte NBYTES-1 SHALL set idx to 0 and move the FSM to HOLD.
REQ-016 An accepted byte with in_sof=1 SHALL be stored as byte 0 and set idx to 1, and any partial word SHALL be discarded without a write.
REQ-017 fifo_wr_en SHALL be combinational and equal (state==HOLD) && !fifo_full.
REQ-018 fifo_din SHALL be registered and stable throughout HOLD.
REQ-019 In HOLD, if fifo_full=0 the word SHALL be written at that edge and the FSM SHALL return to COLLECT.
REQ-020 In HOLD, if fifo_full=0 the block SHALL accept a byte at the same edge as the write; that byte becomes byte 0 of the next word, with in_sof honoured.
REQ-021 Sustained throughput SHALL be one byte per cycle while fifo_full=0.
REQ-022 Latency SHALL be: the last byte is accepted at edge N, and fifo_wr_en is high in the cycle following edge N if fifo_full=0.
REQ-023 Without FIFO_PACKER_DROP_EN, in_ready SHALL equal !reset && ((state==COLLECT) || !fifo_full).
REQ-024 Without FIFO_PACKER_DROP_EN, HOLD SHALL persist while fifo_full=1, the word SHALL never be lost, and upstream SHALL be back-pressured.
REQ-025 Exactly one FIFO write SHALL occur per completed word.
REQ-026 A fifo_full edge arriving at the same clock edge as the write SHALL have no effect, because the decision uses the pre-edge fifo_full value.

Reset
REQ-027 On reset assertion the block SHALL asynchronously force state=COLLECT, idx=0, fifo_din=0 and drop_count=0.
REQ-028 fifo_wr_en and in_ready SHALL be 0 while reset is high.
REQ-029 Reset mid-word or in HOLD SHALL discard the word with no write.
REQ-030 The first byte after reset release SHALL be byte 0 regardless of in_sof.

Configuration
REQ-031 The macro FIFO_PACKER_DROP_EN SHALL select drop mode when defined and back-pressure mode when undefined.
REQ-032 When FIFO_PACKER_DROP_EN is defined, in_ready SHALL equal !reset, and HOLD SHALL last exactly one cycle.
REQ-033 When FIFO_PACKER_DROP_EN is defined and fifo_full=1 in HOLD, the word SHALL be dropped, drop_count SHALL increment saturating at 16'hFFFF, and the FSM SHALL return to COLLECT.
REQ-034 When FIFO_PACKER_DROP_EN is undefined, the drop_count port and its logic SHALL be absent.

Verification
REQ-035 The bench SHALL cover: bytes 0x11,0x22,0x33 on consecutive cycles with fifo_full=0 -> fifo_wr_en high for exactly 1 cycle with fifo_din=0x332211, one cycle after 0x33 is accepted.
REQ-036 The bench SHALL cover: a continuous stream 0x01..0x06 with no gaps -> writes 0x030201 then 0x060504, and in_ready stays 1 throughout.
REQ-037 The bench SHALL cover: fifo_full=1 for 5 cycles while in HOLD, in back-pressure mode -> in_ready=0 and fifo_wr_en=0 during those 5 cycles, then a single write of the held word after fifo_full falls.
REQ-038 The bench SHALL cover: bytes 0xAA,0xBB, then 0xCC with in_sof=1, then 0xDD,0xEE -> exactly one write, fifo_din=0xEEDDCC.
REQ-039 The bench SHALL cover: reset asserted after 2 of 3 bytes -> no write; after release, 0x44,0x55,0x66 -> write 0x665544.
REQ-040 The bench SHALL cover, with FIFO_PACKER_DROP_EN defined: fifo_full held at 1 while 9 bytes are sent -> 3 words dropped, drop_count=3, in_ready=1 throughout, fifo_wr_en never asserted.

Source files
------------

// File: rtl/fifo_byte_packer.sv
// Purpose : packs a byte stream into FIFO_DATA_WIDTH-bit FIFO words, LSB byte first.
// Latency : the word is written in the cycle after its last byte is accepted (fifo_full low).
// Backpr. : fifo_full holds the word and deasserts in_ready; with FIFO_PACKER_DROP_EN the word is dropped instead.
//
// Ports:
//   reset       async active-high reset
//   wr_clk      clock, shared with the FIFO write side
//   in_data     upstream byte, qualified by in_valid; in_sof marks byte 0 of a new word
//   in_ready    byte accepted when in_valid && in_ready at the wr_clk rising edge
//   fifo_wr_en  FIFO write strobe (combinational, never high while fifo_full)
//   fifo_din    registered FIFO write data, stable while a word is held
//   fifo_full   FIFO full flag
//   drop_count  saturating count of dropped words (only with `define FIFO_PACKER_DROP_EN)
module fifo_byte_packer #(
   parameter int FIFO_DATA_WIDTH = 24
) (
   input  logic                       reset,
   input  logic                       wr_clk,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sof,
   output logic                       fifo_wr_en,
   output logic [FIFO_DATA_WIDTH-1:0] fifo_din,
   input  logic                       fifo_full
`ifdef FIFO_PACKER_DROP_EN
   ,
   output logic [15:0]                drop_count
`endif
);

   localparam int NBYTES = FIFO_DATA_WIDTH / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [FIFO_DATA_WIDTH-1:0] din_q, din_d;
   logic [IDX_W-1:0]           pos;
   logic                       last;
   logic                       accept;

`ifdef FIFO_PACKER_DROP_EN
   logic [15:0]                drop_q, drop_d;

   assign drop_count = drop_q;
   // Drop mode never stalls upstream: a word that meets a full FIFO is discarded.
   assign in_ready   = !reset;
`else
   assign in_ready   = !reset && ((state_q == COLLECT) || !fifo_full);
`endif

   assign fifo_wr_en = (state_q == HOLD) && !fifo_full;
   assign fifo_din   = din_q;
   assign accept     = in_valid && in_ready;

   // Byte slot for an incoming byte: sof restarts the word, and a byte taken
   // while holding a word always starts the next one.
   always_comb begin
      pos  = (in_sof || state_q == HOLD) ? '0 : idx_q;
      last = (int'(pos) == NBYTES - 1);
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      din_d   = din_q;
`ifdef FIFO_PACKER_DROP_EN
      drop_d  = drop_q;
`endif
      if (state_q == HOLD) begin
         if (!fifo_full) begin
            state_d = COLLECT;
         end
`ifdef FIFO_PACKER_DROP_EN
         else begin
            state_d = COLLECT;
            if (drop_q != 16'hFFFF) begin
               drop_d = drop_q + 16'd1;
            end
         end
`endif
      end
      // Acceptance after the HOLD decision so a word completing on a single
      // byte still lands in HOLD.
      if (accept) begin
         din_d[8*int'(pos) +: 8] = in_data;
         if (last) begin
            idx_d   = '0;
            state_d = HOLD;
         end else begin
            idx_d   = pos + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         state_q <= COLLECT;
         idx_q   <= '0;
         din_q   <= '0;
`ifdef FIFO_PACKER_DROP_EN
         drop_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         din_q   <= din_d;
`ifdef FIFO_PACKER_DROP_EN
         drop_q  <= drop_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Purpose : self-checking bench for fifo_byte_packer with a word-level reference model.
// Latency : n/a (bench).
// Backpr. : drives fifo_full randomly and in directed stall / drop scenarios.
module tb_fifo_byte_packer;

   localparam int W      = 24;
   localparam int NBYTES = W / 8;

   logic         reset;
   logic         wr_clk;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic         in_sof;
   logic         fifo_wr_en;
   logic [W-1:0] fifo_din;
   logic         fifo_full;
`ifdef FIFO_PACKER_DROP_EN
   logic [15:0]  drop_count;
`endif

   fifo_byte_packer #(.FIFO_DATA_WIDTH(W)) dut (
      .reset      (reset),
      .wr_clk     (wr_clk),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sof     (in_sof),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .fifo_full  (fifo_full)
`ifdef FIFO_PACKER_DROP_EN
      ,
      .drop_count (drop_count)
`endif
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a list of collected bytes plus an optional pending word.
   logic [7:0]   m_bytes[NBYTES];
   int           m_cnt   = 0;
   bit           m_pend  = 0;
   logic [W-1:0] m_word  = '0;
   int           m_drops = 0;
   logic [W-1:0] m_wq[$];
   logic [W-1:0] act_q[$];

   // Inputs change #1 after posedge, so at negedge they describe the next edge.
   always @(negedge wr_clk) begin
      bit exp_rdy;
      bit exp_wr;
      if (reset) begin
         m_cnt  = 0;
         m_pend = 0;
         m_drops = 0;
      end
`ifdef FIFO_PACKER_DROP_EN
      exp_rdy = !reset;
`else
      exp_rdy = !reset && (!m_pend || !fifo_full);
`endif
      exp_wr = m_pend && !fifo_full;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
      if (m_pend) chk("held_word", 32'(fifo_din), 32'(m_word));
      if (reset) chk("reset_din", 32'(fifo_din), 32'd0);
`ifdef FIFO_PACKER_DROP_EN
      chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
      if (fifo_wr_en) act_q.push_back(fifo_din);
      if (!reset) begin
         if (m_pend) begin
            if (!fifo_full) begin
               m_wq.push_back(m_word);
               m_pend = 0;
            end
`ifdef FIFO_PACKER_DROP_EN
            else begin
               m_pend = 0;
               if (m_drops < 65535) m_drops++;
            end
`endif
         end
         if (in_valid && exp_rdy) begin
            if (in_sof) m_cnt = 0;
            m_bytes[m_cnt] = in_data;
            m_cnt++;
            if (m_cnt == NBYTES) begin
               for (int b = 0; b < NBYTES; b++) m_word[8*b +: 8] = m_bytes[b];
               m_pend = 1;
               m_cnt  = 0;
            end
         end
      end
   end

   task automatic step(input logic v, input logic [7:0] d, input logic s, input logic f);
      in_valid  = v;
      in_data   = d;
      in_sof    = s;
      fifo_full = f;
      @(posedge wr_clk);
      #1;
   endtask

   int mark_a = 0;
   int mark_m = 0;

   task automatic mark();
      mark_a = act_q.size();
      mark_m = m_wq.size();
   endtask

   task automatic check_writes(input string nm, input int n, input logic [W-1:0] w0, input logic [W-1:0] w1);
      chk({nm, "_nwr"}, 32'(act_q.size() - mark_a), 32'(n));
      chk({nm, "_model_nwr"}, 32'(m_wq.size() - mark_m), 32'(n));
      if (n >= 1 && act_q.size() > mark_a)     chk({nm, "_w0"}, 32'(act_q[mark_a]), 32'(w0));
      if (n >= 1 && m_wq.size() > mark_m)      chk({nm, "_model_w0"}, 32'(m_wq[mark_m]), 32'(w0));
      if (n >= 2 && act_q.size() > mark_a + 1) chk({nm, "_w1"}, 32'(act_q[mark_a+1]), 32'(w1));
      if (n >= 2 && m_wq.size() > mark_m + 1)  chk({nm, "_model_w1"}, 32'(m_wq[mark_m+1]), 32'(w1));
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_sof    = 1'b0;
      fifo_full = 1'b0;
      repeat (3) @(posedge wr_clk);
      #1;
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("rst_din", 32'(fifo_din), 32'd0);
      reset = 1'b0;
      step(0, 8'h00, 0, 0);

      // Single word, write one cycle after the last byte.
      mark();
      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(1, 8'h33, 0, 0);
      chk("a_wr_en", 32'(fifo_wr_en), 32'd1);
      chk("a_din", 32'(fifo_din), 32'h332211);
      step(0, 8'h00, 0, 0);
      chk("a_wr_en_off", 32'(fifo_wr_en), 32'd0);
      step(0, 8'h00, 0, 0);
      check_writes("a", 1, 24'h332211, '0);

      // Gapless stream keeps in_ready high.
      mark();
      for (int i = 1; i <= 6; i++) begin
         chk("b_ready", 32'(in_ready), 32'd1);
         step(1, 8'(i), 0, 0);
      end
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      check_writes("b", 2, 24'h030201, 24'h060504);

`ifndef FIFO_PACKER_DROP_EN
      // Full FIFO stalls both the held word and upstream.
      mark();
      step(1, 8'hA1, 0, 0);
      step(1, 8'hA2, 0, 0);
      step(1, 8'hA3, 0, 0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'h77; in_sof = 1'b0; fifo_full = 1'b1;
         #1;
         chk("c_ready_stall", 32'(in_ready), 32'd0);
         chk("c_wr_en_stall", 32'(fifo_wr_en), 32'd0);
         step(1, 8'h77, 0, 1);
      end
      in_valid = 1'b0; fifo_full = 1'b0;
      #1;
      chk("c_wr_en_release", 32'(fifo_wr_en), 32'd1);
      chk("c_din_release", 32'(fifo_din), 32'hA3A2A1);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      check_writes("c", 1, 24'hA3A2A1, '0);
`endif

      // sof discards the partial word.
      mark();
      step(1, 8'hAA, 0, 0);
      step(1, 8'hBB, 0, 0);
      step(1, 8'hCC, 1, 0);
      step(1, 8'hDD, 0, 0);
      step(1, 8'hEE, 0, 0);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      check_writes("d", 1, 24'hEEDDCC, '0);

      // Reset mid-word loses the word; the next byte after release is byte 0.
      mark();
      step(1, 8'h12, 0, 0);
      step(1, 8'h34, 0, 0);
      reset = 1'b1;
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      reset = 1'b0;
      step(0, 8'h00, 0, 0);
      check_writes("e_none", 0, '0, '0);
      mark();
      step(1, 8'h44, 0, 0);
      step(1, 8'h55, 0, 0);
      step(1, 8'h66, 0, 0);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      check_writes("e", 1, 24'h665544, '0);

`ifdef FIFO_PACKER_DROP_EN
      // Drop mode: three words meet a full FIFO and are discarded.
      mark();
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h90 + i); in_sof = 1'b0; fifo_full = 1'b1;
         #1;
         chk("f_ready", 32'(in_ready), 32'd1);
         chk("f_wr_en", 32'(fifo_wr_en), 32'd0);
         step(1, 8'(8'h90 + i), 0, 1);
      end
      chk("f_wr_en_last", 32'(fifo_wr_en), 32'd0);
      step(0, 8'h00, 0, 1);
      chk("f_drop_count", 32'(drop_count), 32'd3);
      step(0, 8'h00, 0, 0);
      check_writes("f", 0, '0, '0);
`endif

      // Randomised traffic, fifo_full and occasional resets against the model.
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 10,
              $urandom_range(0, 99) < 30);
      end
      reset = 1'b0;
      repeat (4) step(0, 8'h00, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
